// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, default latencies.
// Imported by mdu, mdu_calc and the stall/forward controllers.
package mdu_pkg;

    localparam logic [2:0] OpNone  = 3'd0;
    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam int unsigned DefMultCycles = 5;
    localparam int unsigned DefDivCycles  = 10;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op >= OpMult) && (op <= OpDivu);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath of the multiply/divide unit: 64-bit {hi,lo} result for the
// selected op plus a divide-by-zero flag.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] dvs;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               ovf;

    always_comb begin
        sprod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod    = {32'd0, a} * {32'd0, b};
        div_zero = (b == 32'd0) && ((op == OpDiv) || (op == OpDivu));
        // Substitute a harmless divisor so the dividers never see zero.
        dvs      = (b == 32'd0) ? 32'd1 : b;
        ovf      = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
        sq       = $signed(a) / $signed(dvs);
        sr       = $signed(a) % $signed(dvs);
        uq       = a / dvs;
        ur       = a % dvs;
        result   = '0;
        case (op)
            OpMult:  result = sprod;
            OpMultu: result = uprod;
            OpDiv:   result = ovf ? {32'h0000_0000, 32'h8000_0000} : {sr, sq};
            OpDivu:  result = {ur, uq};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: start/busy responder with HI/LO registers and mthi/mtlo writes.
// Define MDU_DELAY_EN for the emulated multi-cycle latency; otherwise results commit at once.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DefMultCycles,
    parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mt_we,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_lat
        $error("mdu: latencies must fit the 4-bit counter (1..15)");
    end

    logic [63:0] res;
    logic        div_zero;
    logic        launch;
    logic [63:0] new_hilo;

    mdu_calc u_calc (
        .op      (op),
        .a       (a),
        .b       (b),
        .result  (res),
        .div_zero(div_zero)
    );

    assign launch   = start && is_muldiv(op);
    // Divide by zero re-commits the current HI/LO, which cannot change while in flight.
    assign new_hilo = div_zero ? {hi, lo} : res;

`ifdef MDU_DELAY_EN
    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (launch) begin
                        {p_hi, p_lo} <= new_hilo;
                        cnt   <= ((op == OpMult) || (op == OpMultu)) ? 4'(MULT_CYCLES)
                                                                     : 4'(DIV_CYCLES);
                        busy  <= 1'b1;
                        state <= StRun;
                    end else if (!start && mt_we) begin
                        if (op == OpMthi) hi <= a;
                        if (op == OpMtlo) lo <= a;
                    end
                end
                StRun: begin
                    if (cnt <= 4'd1) begin
                        hi    <= p_hi;
                        lo    <= p_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (launch) begin
            {hi, lo} <= new_hilo;
        end else if (!start && mt_we) begin
            if (op == OpMthi) hi <= a;
            if (op == OpMtlo) lo <= a;
        end
    end
`endif

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit on the execute stage of the pipelined MIPS core: the responder end of the `start`/`busy` handshake that the stall controller already drives and observes. It accepts one mult/div launch per `start` pulse. It holds `busy` high for a fixed emulated latency, then commits a 64-bit result to HI/LO. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: launch the mult/div selected by `op`; one-cycle pulse, sampled while the instruction is in E.
- `mt_we`, input, 1: write HI or LO (mthi/mtlo) selected by `op`.
- `op`, input, 3: operation code from `mdu_pkg`. Values: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
- `a`, input, 32: forwarded rs value.
- `b`, input, 32: forwarded rt value.
- `busy`, output, 1: operation in flight.
- `hi`, output, 32: architectural HI register, driven directly from the register.
- `lo`, output, 32: architectural LO register, driven directly from the register.

## Operation
- States: IDLE and RUN; a 4-bit down-counter `cnt`; pending registers `p_hi` and `p_lo`.
- IDLE, `start`=1 with op in MULT..DIVU:
  - compute the result from `a`/`b` in the same cycle and latch it into `p_hi`/`p_lo`;
  - load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- RUN: decrement `cnt` each cycle. When `cnt` reaches 1, copy `p_hi`/`p_lo` into `hi`/`lo` at that edge and go to IDLE.
- MULT: `{hi,lo}` = signed 32x32 product, 64 bits.
- MULTU: `{hi,lo}` = unsigned 32x32 product, 64 bits.
- DIV: `lo` = signed quotient truncated toward zero; `hi` = remainder, sign of the dividend. 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- DIVU: unsigned quotient in `lo`, remainder in `hi`.
- Divide by zero: runs the full latency; `hi`/`lo` are left unchanged at commit.
- `mt_we`=1 in IDLE with `start`=0:
  - MTHI: `hi` takes `a` at the next edge.
  - MTLO: `lo` takes `a` at the next edge.
  - No busy cycles.
- `start` with op outside MULT..DIVU, and `mt_we` with op outside MTHI/MTLO, are no-ops.
- `start` and `mt_we` both high: `start` wins; the write is dropped.
- `start` or `mt_we` while in RUN: ignored. The stall controller stalls on `start|busy`, so this only arises in a faulty core; the bench checks that it is ignored.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, `p_hi`/`p_lo`=0.
- Reset asserted during RUN discards the pending result.
- `start` sampled at the edge ending cycle T:
  - `busy`=1 in cycles T+1 .. T+N, where N is `MULT_CYCLES` or `DIV_CYCLES`;
  - `busy`=0 and new `hi`/`lo` visible from cycle T+N+1.
- Back-to-back: a new `start` is accepted in cycle T+N+1.
- mthi/mtlo written at the edge ending cycle T are visible in cycle T+1.
- `hi`/`lo` change only at a commit, an mt write or reset. They are never transiently exposed during RUN.

## Configuration
- `MDU_DELAY_EN` defined: latency behaviour as described above.
- `MDU_DELAY_EN` undefined:
  - RUN state and counter are compiled out; `busy` is constant 0;
  - results are written to `hi`/`lo` at the edge that samples `start` and are visible in cycle T+1;
  - divide-by-zero still leaves `hi`/`lo` unchanged.

## Structure
- `mdu_pkg` holds the op encoding constants, the state encoding and the default latency constants. The stall and forward controllers import the same package.
- One combinational sub-module, `mdu_calc`, takes `op`, `a`, `b` and returns the 64-bit `{hi,lo}` result plus a `div_zero` flag. The mdu proper holds only the state, counter and registers.

## Test plan
- MULT a=0xFFFFFFFF, b=2 -> `busy` high for exactly 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- MULTU with the same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `busy` high 10 cycles; `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=7, b=2 -> `lo`=3, `hi`=1.
- MTHI a=0x1234 then DIV with b=0:
  - `hi`=0x1234 the cycle after the write;
  - `busy` high 10 cycles; afterwards `hi`=0x1234 and `lo` unchanged.
- DIV started, then a second `start` and `mt_we` during RUN, then `reset` at busy cycle 4:
  - the extra requests are ignored;
  - the cycle after reset shows `busy`=0, `hi`=0, `lo`=0;
  - a following MULT completes normally.
